// File: rtl/rv32i_types.sv
// Shared RV32I types for the branch update slice.
//   rv32i_opcode : 7-bit major opcode encodings
//   bp_pred_t    : one in-flight prediction {pc, target, isMiss}
//   is_ctrl_flow : true for opcodes that count as control flow
package rv32i_types;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        isMiss;
  } bp_pred_t;

  localparam logic [31:0] PC_STEP = 32'd4;

  function automatic logic is_ctrl_flow(input rv32i_opcode op);
    logic res;
    case (op)
      op_br, op_jal, op_jalr: res = 1'b1;
      default:                res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/branch_update_unit_if.sv
// Bus bundle for branch_update_unit.
//   fetch_* : prediction enqueue side (fetch_ready back to fetch)
//   ex_*    : resolution side from execute
//   redirect/redirect_pc : fetch redirect request
//   upd_*   : BTB update bus
//   br_count/mispredict_count/seq_err : status
// master = the environment (fetch + execute), slave = the unit.
interface branch_update_unit_if #(
  parameter int CNT_W = 32
);
  import rv32i_types::*;

  logic             fetch_valid;
  logic [31:0]      fetch_pc;
  logic [31:0]      fetch_predict_target;
  logic             fetch_isMiss;
  logic             fetch_ready;

  logic             ex_valid;
  logic [31:0]      ex_pc;
  rv32i_opcode      ex_op;
  logic             ex_br_en;
  logic [31:0]      ex_target;

  logic             redirect;
  logic [31:0]      redirect_pc;

  logic             upd_valid;
  logic [31:0]      upd_pc;
  logic [31:0]      upd_target;
  rv32i_opcode      upd_op;
  logic             upd_isMiss;
  logic             upd_br_en;

  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mispredict_count;
  logic             seq_err;

  modport master (
    output fetch_valid, fetch_pc, fetch_predict_target, fetch_isMiss,
    output ex_valid, ex_pc, ex_op, ex_br_en, ex_target,
    input  fetch_ready, redirect, redirect_pc,
    input  upd_valid, upd_pc, upd_target, upd_op, upd_isMiss, upd_br_en,
    input  br_count, mispredict_count, seq_err
  );

  modport slave (
    input  fetch_valid, fetch_pc, fetch_predict_target, fetch_isMiss,
    input  ex_valid, ex_pc, ex_op, ex_br_en, ex_target,
    output fetch_ready, redirect, redirect_pc,
    output upd_valid, upd_pc, upd_target, upd_op, upd_isMiss, upd_br_en,
    output br_count, mispredict_count, seq_err
  );

endinterface

// File: rtl/branch_update_unit_fifo.sv
// bp_pred_fifo: in-order queue of in-flight predictions.
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous flush (wins over push/pop)
//   push/din : write one entry (ignored when full)
//   pop/dout : dout is the head; pop drops it (ignored when empty)
//   full, empty : occupancy flags
module bp_pred_fifo
  import rv32i_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     clr,
  input  logic     push,
  input  logic     pop,
  input  bp_pred_t din,
  output bp_pred_t dout,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  bp_pred_t    mem_r [DEPTH];
  logic        push_ok_s;
  logic        pop_ok_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign dout      = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update with reset and flush.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Payload storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/branch_update_unit.sv
// branch_update_unit: tracks in-flight branch predictions, checks them at
// execute, and drives the fetch redirect, the BTB update bus and counters.
//   clk, rst : clock, synchronous active-high reset
//   bus      : branch_update_unit_if.slave (fetch, execute, redirect,
//              BTB update bus, br/mispredict counters, sticky seq_err)
// All outputs except fetch_ready are registered; fetch_ready is derived
// from the queue pointers only.
module branch_update_unit
  import rv32i_types::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  branch_update_unit_if.slave  bus
);

  bp_pred_t         head_s;
  bp_pred_t         push_data_s;
  logic             full_s;
  logic             empty_s;
  logic             resolve_s;
  logic             push_s;
  logic             taken_s;
  logic             pc_mismatch_s;
  logic             mispredict_s;
  logic             err_s;
  logic             upd_br_en_s;
  logic [31:0]      actual_pc_s;

  logic             redirect_r;
  logic [31:0]      redirect_pc_r;
  logic             upd_valid_r;
  logic [31:0]      upd_pc_r;
  logic [31:0]      upd_target_r;
  rv32i_opcode      upd_op_r;
  logic             upd_isMiss_r;
  logic             upd_br_en_r;
  logic [CNT_W-1:0] br_count_r;
  logic [CNT_W-1:0] mispredict_count_r;
  logic             seq_err_r;

  // Resolve, mispredict and enqueue decisions for this cycle.
  always_comb begin
    taken_s       = 1'b0;
    actual_pc_s   = 32'd0;
    resolve_s     = 1'b0;
    pc_mismatch_s = 1'b0;
    mispredict_s  = 1'b0;
    err_s         = 1'b0;
    push_s        = 1'b0;
    upd_br_en_s   = 1'b0;

    case (bus.ex_op)
      op_jal, op_jalr: taken_s = 1'b1;
      op_br:           taken_s = bus.ex_br_en;
      default:         taken_s = 1'b0;
    endcase

    if (taken_s) begin
      actual_pc_s = bus.ex_target;
    end else begin
      actual_pc_s = bus.ex_pc + PC_STEP;
    end

    resolve_s     = bus.ex_valid & ~empty_s;
    pc_mismatch_s = resolve_s & (bus.ex_pc != head_s.pc);
    mispredict_s  = resolve_s & ((actual_pc_s != head_s.target) | pc_mismatch_s);
    // A resolve with nothing queued is a protocol error, as is a PC that
    // does not match the head entry.
    err_s         = (bus.ex_valid & empty_s) | pc_mismatch_s;
    // Fetches in the cycle that detects a mispredict are wrong-path.
    push_s        = bus.fetch_valid & ~full_s & ~mispredict_s;
    upd_br_en_s   = bus.ex_br_en | (bus.ex_op == op_jal) | (bus.ex_op == op_jalr);
  end

  assign push_data_s = '{pc: bus.fetch_pc, target: bus.fetch_predict_target,
                         isMiss: bus.fetch_isMiss};

  bp_pred_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (mispredict_s),
    .push  (push_s),
    .pop   (resolve_s),
    .din   (push_data_s),
    .dout  (head_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Registered redirect, BTB update bus, counters and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_r         <= 1'b0;
      redirect_pc_r      <= 32'd0;
      upd_valid_r        <= 1'b0;
      upd_pc_r           <= 32'd0;
      upd_target_r       <= 32'd0;
      upd_op_r           <= op_lui;
      upd_isMiss_r       <= 1'b0;
      upd_br_en_r        <= 1'b0;
      br_count_r         <= {CNT_W{1'b0}};
      mispredict_count_r <= {CNT_W{1'b0}};
      seq_err_r          <= 1'b0;
    end else begin
      if (mispredict_s) begin
        redirect_r    <= 1'b1;
        redirect_pc_r <= actual_pc_s;
      end else begin
        redirect_r    <= 1'b0;
      end

      if (resolve_s) begin
        upd_valid_r  <= 1'b1;
        upd_pc_r     <= bus.ex_pc;
        upd_target_r <= bus.ex_target;
        upd_op_r     <= bus.ex_op;
        upd_isMiss_r <= head_s.isMiss;
        upd_br_en_r  <= upd_br_en_s;
      end else begin
        // op_lui with isMiss=0 makes the BTB treat the cycle as no write.
        upd_valid_r  <= 1'b0;
        upd_pc_r     <= 32'd0;
        upd_target_r <= 32'd0;
        upd_op_r     <= op_lui;
        upd_isMiss_r <= 1'b0;
        upd_br_en_r  <= 1'b0;
      end

      if (resolve_s && is_ctrl_flow(bus.ex_op) && (br_count_r != {CNT_W{1'b1}})) begin
        br_count_r <= br_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end

      if (mispredict_s && (mispredict_count_r != {CNT_W{1'b1}})) begin
        mispredict_count_r <= mispredict_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end

      if (err_s) begin
        seq_err_r <= 1'b1;
      end
    end
  end

  assign bus.fetch_ready      = ~full_s;
  assign bus.redirect         = redirect_r;
  assign bus.redirect_pc      = redirect_pc_r;
  assign bus.upd_valid        = upd_valid_r;
  assign bus.upd_pc           = upd_pc_r;
  assign bus.upd_target       = upd_target_r;
  assign bus.upd_op           = upd_op_r;
  assign bus.upd_isMiss       = upd_isMiss_r;
  assign bus.upd_br_en        = upd_br_en_r;
  assign bus.br_count         = br_count_r;
  assign bus.mispredict_count = mispredict_count_r;
  assign bus.seq_err          = seq_err_r;

endmodule

// File: tb/tb_branch_update_unit.sv
// Directed, table-driven bench for branch_update_unit (DEPTH=4, CNT_W=32).
module tb_branch_update_unit;
  import rv32i_types::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  branch_update_unit_if #(.CNT_W(32)) bus ();

  branch_update_unit #(
    .DEPTH (4),
    .CNT_W (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        f_v;
    logic [31:0] f_pc;
    logic [31:0] f_pt;
    logic        f_m;
    logic        e_v;
    logic [31:0] e_pc;
    rv32i_opcode e_op;
    logic        e_br;
    logic [31:0] e_tg;
    logic        x_rd;
    logic [31:0] x_rpc;
    logic        x_uv;
    logic        x_um;
    logic        x_ub;
    logic [31:0] x_br;
    logic [31:0] x_mis;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];
  logic [31:0] exp_q [$];

  function automatic vec_t mkv(
    input logic f_v, input logic [31:0] f_pc, input logic [31:0] f_pt, input logic f_m,
    input logic e_v, input logic [31:0] e_pc, input rv32i_opcode e_op, input logic e_br,
    input logic [31:0] e_tg, input logic x_rd, input logic [31:0] x_rpc, input logic x_uv,
    input logic x_um, input logic x_ub, input logic [31:0] x_br, input logic [31:0] x_mis);
    vec_t v;
    v.f_v = f_v; v.f_pc = f_pc; v.f_pt = f_pt; v.f_m = f_m;
    v.e_v = e_v; v.e_pc = e_pc; v.e_op = e_op; v.e_br = e_br; v.e_tg = e_tg;
    v.x_rd = x_rd; v.x_rpc = x_rpc; v.x_uv = x_uv; v.x_um = x_um; v.x_ub = x_ub;
    v.x_br = x_br; v.x_mis = x_mis;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic set_fetch(input logic v, input logic [31:0] pc, input logic [31:0] pt,
                           input logic m);
    bus.fetch_valid = v; bus.fetch_pc = pc; bus.fetch_predict_target = pt; bus.fetch_isMiss = m;
  endtask

  task automatic set_ex(input logic v, input logic [31:0] pc, input rv32i_opcode op,
                        input logic br, input logic [31:0] tg);
    bus.ex_valid = v; bus.ex_pc = pc; bus.ex_op = op; bus.ex_br_en = br; bus.ex_target = tg;
  endtask

  task automatic idle();
    set_fetch(1'b0, 32'd0, 32'd0, 1'b0);
    set_ex(1'b0, 32'd0, op_lui, 1'b0, 32'd0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " ready"},       32'(bus.fetch_ready), 32'd1);
    chk({tag, " redirect"},    32'(bus.redirect), 32'd0);
    chk({tag, " redirect_pc"}, bus.redirect_pc, 32'd0);
    chk({tag, " upd_valid"},   32'(bus.upd_valid), 32'd0);
    chk({tag, " upd_pc"},      bus.upd_pc, 32'd0);
    chk({tag, " upd_target"},  bus.upd_target, 32'd0);
    chk({tag, " upd_op"},      32'(bus.upd_op), 32'(op_lui));
    chk({tag, " upd_isMiss"},  32'(bus.upd_isMiss), 32'd0);
    chk({tag, " upd_br_en"},   32'(bus.upd_br_en), 32'd0);
    chk({tag, " br_count"},    bus.br_count, 32'd0);
    chk({tag, " mis_count"},   bus.mispredict_count, 32'd0);
    chk({tag, " seq_err"},     32'(bus.seq_err), 32'd0);
  endtask

  initial begin
    logic [31:0] pc;
    checks = 0;
    errors = 0;
    // f_v pc pt m | e_v pc op br tg | redir rpc uv umiss ubr br mis
    vecs[0]  = mkv(1, 32'h60, 32'h64, 1,  0, 32'h0, op_lui, 0, 32'h0,
                   0, 32'h0, 0, 0, 0, 32'd0, 32'd0);
    vecs[1]  = mkv(0, 32'h0, 32'h0, 0,  1, 32'h60, op_br, 0, 32'h80,
                   0, 32'h0, 1, 1, 0, 32'd1, 32'd0);
    vecs[2]  = mkv(1, 32'h60, 32'h64, 1,  0, 32'h0, op_lui, 0, 32'h0,
                   0, 32'h0, 0, 0, 0, 32'd1, 32'd0);
    // Taken branch mispredicts; the simultaneous fetch of 0x200 is dropped.
    vecs[3]  = mkv(1, 32'h200, 32'h204, 0,  1, 32'h60, op_br, 1, 32'h80,
                   1, 32'h80, 1, 1, 1, 32'd2, 32'd1);
    vecs[4]  = mkv(1, 32'h10, 32'h40, 0,  0, 32'h0, op_lui, 0, 32'h0,
                   0, 32'h0, 0, 0, 0, 32'd2, 32'd1);
    vecs[5]  = mkv(0, 32'h0, 32'h0, 0,  1, 32'h10, op_jalr, 0, 32'h44,
                   1, 32'h44, 1, 0, 1, 32'd3, 32'd2);
    vecs[6]  = mkv(1, 32'h100, 32'h104, 0,  0, 32'h0, op_lui, 0, 32'h0,
                   0, 32'h0, 0, 0, 0, 32'd3, 32'd2);
    // Non-control-flow op: br_en passes to upd_br_en but is not "taken".
    vecs[7]  = mkv(0, 32'h0, 32'h0, 0,  1, 32'h100, op_reg, 1, 32'h500,
                   0, 32'h0, 1, 0, 1, 32'd3, 32'd2);
    vecs[8]  = mkv(1, 32'h200, 32'h300, 0,  0, 32'h0, op_lui, 0, 32'h0,
                   0, 32'h0, 0, 0, 0, 32'd3, 32'd2);
    vecs[9]  = mkv(0, 32'h0, 32'h0, 0,  1, 32'h200, op_jal, 0, 32'h300,
                   0, 32'h0, 1, 0, 1, 32'd4, 32'd2);
    // pc+4 wraps to 0 and matches the prediction.
    vecs[10] = mkv(1, 32'hFFFF_FFFC, 32'h0, 1,  0, 32'h0, op_lui, 0, 32'h0,
                   0, 32'h0, 0, 0, 0, 32'd4, 32'd2);
    vecs[11] = mkv(0, 32'h0, 32'h0, 0,  1, 32'hFFFF_FFFC, op_br, 0, 32'h1234,
                   0, 32'h0, 1, 1, 0, 32'd5, 32'd2);

    idle();
    rst = 1'b1;
    cyc();
    cyc();
    check_reset("reset");
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      set_fetch(vecs[i].f_v, vecs[i].f_pc, vecs[i].f_pt, vecs[i].f_m);
      set_ex(vecs[i].e_v, vecs[i].e_pc, vecs[i].e_op, vecs[i].e_br, vecs[i].e_tg);
      cyc();
      chk($sformatf("v%0d ready", i), 32'(bus.fetch_ready), 32'd1);
      chk($sformatf("v%0d redirect", i), 32'(bus.redirect), 32'(vecs[i].x_rd));
      if (vecs[i].x_rd) begin
        chk($sformatf("v%0d redirect_pc", i), bus.redirect_pc, vecs[i].x_rpc);
      end
      chk($sformatf("v%0d upd_valid", i), 32'(bus.upd_valid), 32'(vecs[i].x_uv));
      if (vecs[i].x_uv) begin
        chk($sformatf("v%0d upd_pc", i), bus.upd_pc, vecs[i].e_pc);
        chk($sformatf("v%0d upd_target", i), bus.upd_target, vecs[i].e_tg);
        chk($sformatf("v%0d upd_op", i), 32'(bus.upd_op), 32'(vecs[i].e_op));
        chk($sformatf("v%0d upd_isMiss", i), 32'(bus.upd_isMiss), 32'(vecs[i].x_um));
        chk($sformatf("v%0d upd_br_en", i), 32'(bus.upd_br_en), 32'(vecs[i].x_ub));
      end else begin
        chk($sformatf("v%0d idle upd_op", i), 32'(bus.upd_op), 32'(op_lui));
        chk($sformatf("v%0d idle upd_isMiss", i), 32'(bus.upd_isMiss), 32'd0);
      end
      chk($sformatf("v%0d br_count", i), bus.br_count, vecs[i].x_br);
      chk($sformatf("v%0d mis_count", i), bus.mispredict_count, vecs[i].x_mis);
      chk($sformatf("v%0d seq_err", i), 32'(bus.seq_err), 32'd0);
    end
    idle();

    // Fill to DEPTH; fetch_ready drops only after the 4th entry, which also
    // shows the fetch dropped during the redirect never entered the queue.
    for (int i = 0; i < 4; i++) begin
      pc = 32'h1000 + 32'(4 * i);
      set_fetch(1'b1, pc, pc + 32'd4, 1'b0);
      exp_q.push_back(pc);
      cyc();
      chk($sformatf("fill%0d ready", i), 32'(bus.fetch_ready), (i == 3) ? 32'd0 : 32'd1);
    end
    set_fetch(1'b1, 32'hDEAD_0000, 32'hDEAD_0004, 1'b0);
    cyc();
    chk("full 5th ready", 32'(bus.fetch_ready), 32'd0);

    // One lone pop, then push+pop together across the pointer wrap.
    idle();
    pc = exp_q.pop_front();
    set_ex(1'b1, pc, op_reg, 1'b0, 32'h0);
    cyc();
    chk("lone pop upd_pc", bus.upd_pc, 32'h1000);
    chk("lone pop ready", 32'(bus.fetch_ready), 32'd1);
    for (int k = 0; k < 8; k++) begin
      pc = 32'h1010 + 32'(4 * k);
      set_fetch(1'b1, pc, pc + 32'd4, 1'b0);
      exp_q.push_back(pc);
      pc = exp_q.pop_front();
      set_ex(1'b1, pc, op_reg, 1'b0, 32'h0);
      cyc();
      chk($sformatf("wrap%0d upd_valid", k), 32'(bus.upd_valid), 32'd1);
      chk($sformatf("wrap%0d upd_pc", k), bus.upd_pc, pc);
      chk($sformatf("wrap%0d redirect", k), 32'(bus.redirect), 32'd0);
      chk($sformatf("wrap%0d seq_err", k), 32'(bus.seq_err), 32'd0);
      chk($sformatf("wrap%0d ready", k), 32'(bus.fetch_ready), 32'd1);
    end
    // Occupancy must still be 3: one more push fills it.
    idle();
    pc = 32'h1030;
    set_fetch(1'b1, pc, pc + 32'd4, 1'b0);
    exp_q.push_back(pc);
    cyc();
    chk("refill ready", 32'(bus.fetch_ready), 32'd0);
    idle();
    for (int k = 0; k < 4; k++) begin
      pc = exp_q.pop_front();
      set_ex(1'b1, pc, op_reg, 1'b0, 32'h0);
      cyc();
      chk($sformatf("drain%0d upd_pc", k), bus.upd_pc, pc);
      chk($sformatf("drain%0d redirect", k), 32'(bus.redirect), 32'd0);
    end
    idle();
    cyc();
    chk("drain seq_err", 32'(bus.seq_err), 32'd0);
    chk("drain br_count", bus.br_count, 32'd5);
    chk("drain mis_count", bus.mispredict_count, 32'd2);

    // PC mismatch: counts as mispredict and sets seq_err.
    set_fetch(1'b1, 32'h2000, 32'h2004, 1'b0);
    cyc();
    idle();
    set_ex(1'b1, 32'h2008, op_br, 1'b0, 32'h0);
    cyc();
    idle();
    chk("pcmis redirect", 32'(bus.redirect), 32'd1);
    chk("pcmis redirect_pc", bus.redirect_pc, 32'h200C);
    chk("pcmis seq_err", 32'(bus.seq_err), 32'd1);
    chk("pcmis mis_count", bus.mispredict_count, 32'd3);
    chk("pcmis br_count", bus.br_count, 32'd6);
    cyc();
    chk("pcmis redirect pulse", 32'(bus.redirect), 32'd0);

    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check_reset("reset2");

    // Resolve on an empty queue.
    set_ex(1'b1, 32'h0, op_br, 1'b1, 32'h40);
    cyc();
    idle();
    chk("empty seq_err", 32'(bus.seq_err), 32'd1);
    chk("empty upd_valid", 32'(bus.upd_valid), 32'd0);
    chk("empty redirect", 32'(bus.redirect), 32'd0);
    chk("empty br_count", bus.br_count, 32'd0);
    cyc();
    cyc();
    chk("sticky seq_err", 32'(bus.seq_err), 32'd1);

    // Two entries queued, then rst together with a mispredicting resolve.
    set_fetch(1'b1, 32'h3000, 32'h3004, 1'b1);
    cyc();
    set_fetch(1'b1, 32'h3004, 32'h3008, 1'b1);
    cyc();
    set_fetch(1'b1, 32'h3008, 32'h300C, 1'b1);
    set_ex(1'b1, 32'h3000, op_jal, 1'b0, 32'h5000);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    idle();
    check_reset("midrst");
    cyc();
    chk("midrst redirect", 32'(bus.redirect), 32'd0);
    for (int i = 0; i < 4; i++) begin
      pc = 32'h4000 + 32'(4 * i);
      set_fetch(1'b1, pc, pc + 32'd4, 1'b0);
      cyc();
      chk($sformatf("post-rst fill%0d ready", i), 32'(bus.fetch_ready),
          (i == 3) ? 32'd0 : 32'd1);
    end
    idle();
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
